// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the 8-bit pipeline hazard controller: opcodes, FSM states,
// the NOP word and the RAW-hazard detection rule.
package pipeline_ctrl_pkg;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [7:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HOLD  = 2'b10,
    ST_ILL   = 2'b11
  } state_t;

  // r0 is never a hazard source, so NOP (MOV r0,r0) and writes to r0 are harmless.
  function automatic logic raw_hazard(input logic [7:0] id, input logic [7:0] ex);
    logic [2:0] ex_rd;
    ex_rd      = ex[5:3];
    raw_hazard = 1'b0;
    if (ex[7:6] != OP_JMP && ex_rd != 3'd0) begin
      case (id[7:6])
        OP_MOV:  raw_hazard = (id[2:0] == ex_rd);
        OP_ADD:  raw_hazard = (id[5:3] == ex_rd) || (id[2:0] == ex_rd);
        default: raw_hazard = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && r_count != '1) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Front-end hazard controller: inserts RAW bubbles, handles jumps and external holds,
// and keeps saturating statistics of jumps taken and stalls entered.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned HAZ_STALL = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       if_instr,
  input  logic [7:0]       id_instr,
  input  logic [7:0]       ex_instr,
  input  logic             hold_req,
  input  logic             clr_stats,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_bubble,
  output logic             pc_sel_jump,
  output logic [5:0]       jump_target,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [2:0] STALL_LOAD = 3'(HAZ_STALL - 1);

  state_t     r_state, w_next_state;
  logic [2:0] r_stall_cnt, w_stall_cnt_nxt;
  logic       w_hazard, w_jump;
  logic       w_pc_we, w_ifid_we, w_bubble, w_sel_jump;
  logic       w_flush_inc, w_stall_inc;

  assign w_hazard = raw_hazard(id_instr, ex_instr);
  assign w_jump   = (if_instr[7:6] == OP_JMP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_pc_we         = 1'b0;
    w_ifid_we       = 1'b0;
    w_bubble        = 1'b0;
    w_sel_jump      = 1'b0;
    w_flush_inc     = 1'b0;
    w_stall_inc     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (hold_req) begin
          w_next_state = ST_HOLD;
        end else if (w_hazard) begin
          // A jump in IF is held back and re-evaluated once the bubbles drain.
          w_bubble        = 1'b1;
          w_stall_inc     = 1'b1;
          w_stall_cnt_nxt = STALL_LOAD;
          w_next_state    = (HAZ_STALL > 1) ? ST_STALL : ST_RUN;
        end else begin
          w_pc_we     = 1'b1;
          w_ifid_we   = 1'b1;
          w_sel_jump  = w_jump;
          w_flush_inc = w_jump;
        end
      end
      ST_STALL: begin
        w_bubble = 1'b1;
        if (hold_req) begin
          w_next_state    = ST_HOLD;
          w_stall_cnt_nxt = '0;
        end else if (r_stall_cnt <= 3'd1) begin
          w_next_state    = ST_RUN;
          w_stall_cnt_nxt = '0;
        end else begin
          w_stall_cnt_nxt = r_stall_cnt - 3'd1;
        end
      end
      ST_HOLD: begin
        if (!hold_req) begin
          w_next_state    = ST_RUN;
          w_stall_cnt_nxt = '0;
        end
      end
      default: begin
        w_next_state    = ST_RUN;
        w_stall_cnt_nxt = '0;
      end
    endcase
  end

  assign pc_we       = w_pc_we    & reset;
  assign ifid_we     = w_ifid_we  & reset;
  assign idex_bubble = w_bubble   & reset;
  assign pc_sel_jump = w_sel_jump & reset;
  assign jump_target = if_instr[5:0];
  assign state       = r_state;

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (w_flush_inc),
    .count (flush_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (w_stall_inc),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: HAZ_STALL=1 and HAZ_STALL=3 instances share
// stimulus and are compared each cycle against an owed-bubble/held-flag reference model.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] if_i, id_i, ex_i;
  logic       hold, clr;

  logic [1:0] pc_we_w, ifid_we_w, bub_w, sel_w;
  logic [5:0] jt_w    [2];
  logic [1:0] st_w    [2];
  logic [7:0] fcnt_w  [2];
  logic [7:0] scnt_w  [2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bubbles still owed after the current cycle, and hold status.
  int m_bub  [2];
  bit m_held [2];
  int m_fl   [2];
  int m_sc   [2];

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.HAZ_STALL(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(rst_n), .if_instr(if_i), .id_instr(id_i), .ex_instr(ex_i),
    .hold_req(hold), .clr_stats(clr), .pc_we(pc_we_w[0]), .ifid_we(ifid_we_w[0]),
    .idex_bubble(bub_w[0]), .pc_sel_jump(sel_w[0]), .jump_target(jt_w[0]),
    .state(st_w[0]), .flush_count(fcnt_w[0]), .stall_count(scnt_w[0])
  );

  pipeline_hazard_controller #(.HAZ_STALL(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .reset(rst_n), .if_instr(if_i), .id_instr(id_i), .ex_instr(ex_i),
    .hold_req(hold), .clr_stats(clr), .pc_we(pc_we_w[1]), .ifid_we(ifid_we_w[1]),
    .idex_bubble(bub_w[1]), .pc_sel_jump(sel_w[1]), .jump_target(jt_w[1]),
    .state(st_w[1]), .flush_count(fcnt_w[1]), .stall_count(scnt_w[1])
  );

  function automatic int hs(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Registers read by an instruction, as a bitmask over r0..r7.
  function automatic logic [7:0] reads_of(input logic [7:0] ins);
    logic [7:0] m;
    m = 8'h00;
    if (ins[7:6] == 2'd0) m[ins[2:0]] = 1'b1;
    if (ins[7:6] == 2'd1) begin
      m[ins[2:0]] = 1'b1;
      m[ins[5:3]] = 1'b1;
    end
    return m;
  endfunction

  function automatic bit ref_hazard();
    logic [7:0] rd_mask;
    int         wr;
    rd_mask = reads_of(id_i);
    wr      = int'(ex_i[5:3]);
    return (ex_i[7:6] != 2'd3) && (wr != 0) && rd_mask[wr];
  endfunction

  function automatic logic [27:0] obs(input int k);
    return {pc_we_w[k], ifid_we_w[k], bub_w[k], sel_w[k], jt_w[k], st_w[k], fcnt_w[k], scnt_w[k]};
  endfunction

  function automatic logic [27:0] exp_vec(input int k);
    logic       pw, iw, bb, sj;
    logic [1:0] st;
    pw = 0; iw = 0; bb = 0; sj = 0;
    st = m_held[k] ? 2'd2 : (m_bub[k] > 0 ? 2'd1 : 2'd0);
    if (rst_n === 1'b1) begin
      if (m_held[k]) begin
      end else if (m_bub[k] > 0) begin
        bb = 1;
      end else if (hold) begin
      end else if (ref_hazard()) begin
        bb = 1;
      end else begin
        pw = 1; iw = 1; sj = (if_i[7:6] == 2'd3);
      end
    end
    return {pw, iw, bb, sj, if_i[5:0], st, 8'(m_fl[k]), 8'(m_sc[k])};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bub[k] = 0; m_held[k] = 0; m_fl[k] = 0; m_sc[k] = 0;
    end
  endfunction

  function automatic void model_update();
    bit haz, jmp, running, took_jump, took_haz;
    if (rst_n !== 1'b1) return;
    haz = ref_hazard();
    jmp = (if_i[7:6] == 2'd3);
    for (int k = 0; k < 2; k++) begin
      running   = !m_held[k] && m_bub[k] == 0 && !hold;
      took_jump = running && !haz && jmp;
      took_haz  = running && haz;
      if (m_held[k]) m_held[k] = hold;
      else if (m_bub[k] > 0) begin
        if (hold) begin m_held[k] = 1; m_bub[k] = 0; end
        else m_bub[k]--;
      end else if (hold) m_held[k] = 1;
      else if (haz) m_bub[k] = hs(k) - 1;
      if (clr) begin
        m_fl[k] = 0; m_sc[k] = 0;
      end else begin
        if (took_jump && m_fl[k] < 255) m_fl[k]++;
        if (took_haz && m_sc[k] < 255) m_sc[k]++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] fi, input logic [7:0] di, input logic [7:0] ei,
                       input logic h, input logic c);
    if_i = fi; id_i = di; ex_i = ei; hold = h; clr = c;
  endtask

  task automatic test_reset();
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== exp_vec(k)) begin
        $display("FAIL reset dut%0d got=%h exp=%h", k, obs(k), exp_vec(k)); n_err++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raw_stall();
    logic [1:0] seq3 [4];
    seq3[0] = 2'd0; seq3[1] = 2'd1; seq3[2] = 2'd1; seq3[3] = 2'd0;
    for (int c = 0; c < 5; c++) begin
      drive(8'h00, 8'h11, (c == 0) ? 8'h48 : 8'h00, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          $display("FAIL raw_stall c%0d dut%0d got=%h exp=%h", c, k, obs(k), exp_vec(k)); n_err++;
        end
      end
      if (c < 4) begin
        n_cmp++;
        if (st_w[1] !== seq3[c]) begin
          $display("FAIL raw_state_seq c%0d got=%0d exp=%0d", c, st_w[1], seq3[c]); n_err++;
        end
      end
      tick();
    end
  endtask

  task automatic test_jump();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(8'hC5, 8'h11, 8'h00, 1'b0, 1'b0);
        1:       drive(8'hC5, 8'h11, 8'h48, 1'b0, 1'b0);
        default: drive(8'hC5, 8'h11, 8'h00, 1'b0, 1'b0);
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          $display("FAIL jump c%0d dut%0d got=%h exp=%h", c, k, obs(k), exp_vec(k)); n_err++;
        end
      end
      if (c < 3) begin
        n_cmp++;
        if ({sel_w[0], jt_w[0]} !== ((c == 1) ? 7'h05 : 7'h45)) begin
          $display("FAIL jump_direct c%0d got=%h exp=%h", c, {sel_w[0], jt_w[0]},
                   (c == 1) ? 7'h05 : 7'h45); n_err++;
        end
      end
      tick();
    end
  endtask

  task automatic test_hold_in_stall();
    for (int c = 0; c < 9; c++) begin
      drive(8'h00, 8'h11, 8'h48, (c >= 1 && c <= 4), 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          $display("FAIL hold_stall c%0d dut%0d got=%h exp=%h", c, k, obs(k), exp_vec(k)); n_err++;
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({st_w[1], pc_we_w[1], ifid_we_w[1], bub_w[1], sel_w[1]} !== 6'b10_0000) begin
          $display("FAIL hold_direct got=%b exp=100000",
                   {st_w[1], pc_we_w[1], ifid_we_w[1], bub_w[1], sel_w[1]}); n_err++;
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 262; c++) begin
      drive(8'hC0 | 8'(c & 63), 8'h00, 8'h00, 1'b0, (c == 0));
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          $display("FAIL saturate c%0d dut%0d got=%h exp=%h", c, k, obs(k), exp_vec(k)); n_err++;
        end
      end
      tick();
    end
    n_cmp++;
    if (fcnt_w[0] !== 8'hFF) begin
      $display("FAIL flush_sat got=%h exp=ff", fcnt_w[0]); n_err++;
    end
    drive(8'hC1, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (fcnt_w[0] !== 8'h00 || fcnt_w[1] !== 8'h00) begin
      $display("FAIL clr_over_inc got=%h/%h exp=00/00", fcnt_w[0], fcnt_w[1]); n_err++;
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(8'h00, 8'h11, 8'h48, 1'b0, 1'b0);
    tick();
    drive(8'h00, 8'h11, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== exp_vec(k)) begin
        $display("FAIL reset_mid_stall dut%0d got=%h exp=%h", k, obs(k), exp_vec(k)); n_err++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== exp_vec(k)) begin
        $display("FAIL after_release dut%0d got=%h exp=%h", k, obs(k), exp_vec(k)); n_err++;
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic h;
    h = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) h = ~h;
      drive(8'($urandom), 8'($urandom), 8'($urandom), h, ($urandom_range(0, 31) == 0));
      if ($urandom_range(0, 5) == 0) ex_i[5:3] = id_i[2:0];
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          $display("FAIL random c%0d dut%0d got=%h exp=%h", c, k, obs(k), exp_vec(k)); n_err++;
        end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_raw_stall();
    test_jump();
    test_hold_in_stall();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
